// File: rtl/config_frame_sequencer.sv
// config_frame_sequencer
// Turns the serial configuration word stream into fabric row writes.
// Frame format: sync word, header word (column / frame address), then
// NUM_ROWS data words. Each data word is re-issued as a registered row write;
// the completed frame is committed into the columns with LongFrameStrobe.
//
// Optional feature macro: CFG_FRAME_CHECK_EN
//   Each frame carries a trailing checksum word equal to the XOR of the header
//   and all data words. The commit is issued only when the checksum matches;
//   a mismatch sets the sticky ErrorFlag instead.
module config_frame_sequencer #(
  parameter int NUM_ROWS  = 16,
  parameter int NUM_COLS  = 16,
  parameter int ROW_SEL_W = 5
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic [31:0]          ConfigWriteData,
  input  logic                 ConfigWriteStrobe,
  output logic [31:0]          RowData,
  output logic [ROW_SEL_W-1:0] RowSelect,
  output logic                 RowWriteStrobe,
  output logic [31:0]          FrameAddressRegister,
  output logic                 LongFrameStrobe,
  output logic                 Active,
  output logic                 ErrorFlag
);

  localparam logic [31:0]          SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0]          DESYNC_WORD = 32'hFAB0_FAB0;
  localparam logic [31:0]          COL_LIMIT   = NUM_COLS;
  localparam logic [ROW_SEL_W-1:0] LAST_ROW    = ROW_SEL_W'(NUM_ROWS - 1);

`ifdef CFG_FRAME_CHECK_EN
  typedef enum logic [1:0] {IDLE, HEADER, DATA, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
`endif

  state_t                 state;
  logic [ROW_SEL_W-1:0]   row_cnt;
  logic                   frame_bad;   // current frame addresses a non-existent column
  logic                   col_bad;
`ifdef CFG_FRAME_CHECK_EN
  logic [31:0]            chk_acc;     // running XOR of header and data words
`endif

  // Column index of the incoming word, checked when it is taken as a header.
  assign col_bad = ({24'd0, ConfigWriteData[31:24]} >= COL_LIMIT);

  // Frame sequencer: state, row counter and all registered outputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state                <= IDLE;
      row_cnt              <= '0;
      frame_bad            <= 1'b0;
      RowData              <= '0;
      RowSelect            <= '0;
      RowWriteStrobe       <= 1'b0;
      FrameAddressRegister <= '0;
      LongFrameStrobe      <= 1'b0;
      Active               <= 1'b0;
      ErrorFlag            <= 1'b0;
`ifdef CFG_FRAME_CHECK_EN
      chk_acc              <= '0;
`endif
    end else begin
      // NOTE: every register here uses <= so all reads in this block see the
      // pre-edge values; the strobes default low so each is a one-cycle pulse.
      RowWriteStrobe  <= 1'b0;
      LongFrameStrobe <= 1'b0;

      if (ConfigWriteStrobe) begin
        case (state)
          IDLE: begin
            if (ConfigWriteData == SYNC_WORD) begin
              state  <= HEADER;
              Active <= 1'b1;
            end
          end

          HEADER: begin
            if (ConfigWriteData == DESYNC_WORD) begin
              state  <= IDLE;
              Active <= 1'b0;
            end else begin
              FrameAddressRegister <= ConfigWriteData;
              row_cnt              <= '0;
              frame_bad            <= col_bad;
              if (col_bad) ErrorFlag <= 1'b1;
`ifdef CFG_FRAME_CHECK_EN
              chk_acc              <= ConfigWriteData;
`endif
              state                <= DATA;
            end
          end

          DATA: begin
            // Sync/desync values are ordinary data here.
            RowData        <= ConfigWriteData;
            RowSelect      <= row_cnt;
            RowWriteStrobe <= !frame_bad;
`ifdef CFG_FRAME_CHECK_EN
            chk_acc        <= chk_acc ^ ConfigWriteData;
`endif
            if (row_cnt == LAST_ROW) begin
              // Counter holds at the last row; only a header clears it.
`ifdef CFG_FRAME_CHECK_EN
              state           <= CHECK;
`else
              state           <= HEADER;
              LongFrameStrobe <= !frame_bad;
`endif
            end else begin
              row_cnt <= row_cnt + ROW_SEL_W'(1);
            end
          end

`ifdef CFG_FRAME_CHECK_EN
          CHECK: begin
            state <= HEADER;
            if (ConfigWriteData == chk_acc) begin
              LongFrameStrobe <= !frame_bad;
            end else begin
              ErrorFlag <= 1'b1;
            end
          end
`endif

          default: begin
            state  <= IDLE;
            Active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/config_frame_sequencer.md
CONFIG_FRAME_SEQUENCER -- requirements
Module: config_frame_sequencer

Interface
REQ-001 Parameter NUM_ROWS, default 16: number of fabric rows, i.e. data words per frame.
REQ-002 Parameter NUM_COLS, default 16: number of fabric columns; highest legal column index is NUM_COLS-1.
REQ-003 Parameter ROW_SEL_W, default 5: width of RowSelect.
REQ-004 CLK  in  1  single clock for all logic; one clock, every flop on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 ConfigWriteData  in  32  configuration word from the upstream config port mux.
REQ-007 ConfigWriteStrobe  in  1  one-cycle qualifier for ConfigWriteData; may be asserted on consecutive cycles.
REQ-008 RowData  out  32  registered copy of the accepted data word.
REQ-009 RowSelect  out  ROW_SEL_W  row index of RowData, 0..NUM_ROWS-1.
REQ-010 RowWriteStrobe  out  1  one-cycle pulse; RowData and RowSelect are valid while it is high.
REQ-011 FrameAddressRegister  out  32  header word of the current frame.
REQ-012 LongFrameStrobe  out  1  one-cycle pulse that commits the completed frame into the columns.
REQ-013 Active  out  1  high in every state except IDLE.
REQ-014 ErrorFlag  out  1  sticky error flag.

Function
REQ-015 States: IDLE, HEADER, DATA, CHECK. CHECK exists only when CFG_FRAME_CHECK_EN is defined.
REQ-016 A state advances only on a cycle with ConfigWriteStrobe=1; with strobe low, state and all registers hold.
REQ-017 IDLE: the word 0xFAB0_FAB1 -> HEADER; any other word is ignored.
REQ-018 HEADER: the word 0xFAB0_FAB0 (desync) -> IDLE.
REQ-019 HEADER: any other word is latched into FrameAddressRegister, the row counter is cleared to 0, and the state -> DATA.
REQ-020 Header fields: [31:24] column index; [4:0] frame index within the column.
REQ-021 A column index >= NUM_COLS sets ErrorFlag, and the whole frame is consumed with RowWriteStrobe and LongFrameStrobe suppressed.
REQ-022 DATA: each word -> RowData = word, RowSelect = counter, RowWriteStrobe = 1 on the next cycle (latency 1); the counter then increments.
REQ-023 DATA: the sync and desync values are treated as ordinary data.
REQ-024 DATA: after word NUM_ROWS-1 is accepted, the state -> CHECK if the macro is defined, else -> HEADER.
REQ-025 Without the macro, LongFrameStrobe pulses in the same cycle as the last RowWriteStrobe.
REQ-026 No dead cycle at frame boundaries: the next header is accepted on the cycle immediately after the last data word.
REQ-027 The row counter width is ROW_SEL_W; it never exceeds NUM_ROWS-1, and wrap to 0 occurs only through a header.
REQ-028 ErrorFlag clears only on reset.

Reset
REQ-029 resetn low, asynchronously: state = IDLE, counter = 0, RowData = 0, RowSelect = 0, FrameAddressRegister = 0, all strobes 0, Active = 0, ErrorFlag = 0.
REQ-030 Reset mid-frame discards the partial frame; no LongFrameStrobe is issued for it.
REQ-031 The first strobe after release is honoured on the first rising CLK edge with resetn high.

Configuration
REQ-032 Macro CFG_FRAME_CHECK_EN: when defined, each frame carries a trailing checksum word, which must equal the XOR of the header and all NUM_ROWS data words.
REQ-033 With the macro defined, the checksum word in CHECK -> HEADER.
REQ-034 With the macro defined, a matching checksum gives LongFrameStrobe one cycle after that word is accepted; a mismatch gives no LongFrameStrobe and sets ErrorFlag.
REQ-035 With the macro defined, RowWriteStrobe pulses are still issued during DATA; only the commit is gated by the check.
REQ-036 Macro undefined: no CHECK state and no checksum word; ErrorFlag reflects only REQ-021.

Verification
REQ-037 Reset, strobe 0x1234_5678 in IDLE -> no output pulses, Active = 0.
REQ-038 NUM_ROWS = 4, macro off: sync, header 0x0200_0003, data D0..D3 on consecutive cycles -> RowSelect 0,1,2,3 with RowData D0..D3; LongFrameStrobe with last RowWriteStrobe; FrameAddressRegister = 0x0200_0003.
REQ-039 Two frames back-to-back without idle cycles -> two LongFrameStrobe pulses exactly 5 cycles apart; then desync 0xFAB0_FAB0 -> Active = 0.
REQ-040 Header column 0xFF with NUM_COLS = 16 -> ErrorFlag = 1, 4 data words consumed, no RowWriteStrobe or LongFrameStrobe; next frame processes normally.
REQ-041 Reset asserted after D1 -> all outputs 0 asynchronously; a fresh full frame afterwards completes correctly.
REQ-042 Macro on: correct XOR word -> LongFrameStrobe one cycle after it is accepted; corrupted checksum (bit 0 flipped) -> no LongFrameStrobe, ErrorFlag = 1.
